// File: rtl/multi_adder_pkg.sv
// Shared types and width helpers for the sequential multi-operand adder.
package multi_adder_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_e;

    // Wide enough for num_ops * (2^n - 1); num_ops == 1 collapses to n bits.
    function automatic int sum_width(input int n, input int num_ops);
        return n + $clog2(num_ops);
    endfunction

    function automatic int idx_width(input int num_ops);
        return (num_ops > 1) ? $clog2(num_ops) : 1;
    endfunction

endpackage

// File: rtl/multi_adder_seq.sv
// Sequential adder: captures NUM_OPS operands in one handshake, sums them one
// per cycle from index 0 upward, then holds the total until the consumer takes it.
module multi_adder_seq
    import multi_adder_pkg::*;
#(
    parameter int N       = 8,
    parameter int NUM_OPS = 8
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [N-1:0]                       in [NUM_OPS-1:0],
    input  logic                               in_valid,
    output logic                               in_ready,
    output logic [sum_width(N, NUM_OPS)-1:0]   sum,
    output logic                               out_valid,
    input  logic                               out_ready
);

    localparam int SW = sum_width(N, NUM_OPS);
    localparam int IW = idx_width(NUM_OPS);
    localparam logic [IW-1:0] LAST_IDX = IW'(NUM_OPS - 1);

    state_e        state_q, state_d;
    logic [N-1:0]  ops_q [NUM_OPS-1:0];
    logic [N-1:0]  ops_d [NUM_OPS-1:0];
    logic [SW-1:0] acc_q, acc_d;
    logic [IW-1:0] idx_q, idx_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            acc_q   <= '0;
            idx_q   <= '0;
            for (int i = 0; i < NUM_OPS; i++) ops_q[i] <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            idx_q   <= idx_d;
            for (int i = 0; i < NUM_OPS; i++) ops_q[i] <= ops_d[i];
        end
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        idx_d   = idx_q;
        for (int i = 0; i < NUM_OPS; i++) ops_d[i] = ops_q[i];

        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    for (int i = 0; i < NUM_OPS; i++) ops_d[i] = in[i];
                    acc_d   = '0;
                    idx_d   = '0;
                    state_d = ACCUM;
                end
            end
            ACCUM: begin
                acc_d = acc_q + SW'(ops_q[idx_q]);
                // The index parks on the last operand instead of wrapping past it.
                if (idx_q == LAST_IDX) begin
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + IW'(1);
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign sum       = acc_q;

endmodule

// File: tb/tb_multi_adder_seq.sv
// Randomized scoreboard bench for multi_adder_seq with an arithmetic reference model.
module tb_multi_adder_seq;

    localparam int N       = 8;
    localparam int NUM_OPS = 8;
    localparam int SW      = N + $clog2(NUM_OPS);
    localparam int LAT     = NUM_OPS + 1;
    localparam int PER     = NUM_OPS + 2;

    typedef logic [N-1:0] vec_t [NUM_OPS-1:0];
    typedef struct {
        longint sum;
        int     acc_cyc;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  din [NUM_OPS-1:0];
    logic          in_valid;
    logic          in_ready;
    logic [SW-1:0] sum;
    logic          out_valid;
    logic          out_ready;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   last_acc = -1;
    bit   spacing_on = 1'b0;
    exp_t sb[$];

    multi_adder_seq #(.N(N), .NUM_OPS(NUM_OPS)) dut (
        .clk(clk), .rst(rst), .in(din), .in_valid(in_valid), .in_ready(in_ready),
        .sum(sum), .out_valid(out_valid), .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic scramble();
        for (int i = 0; i < NUM_OPS; i++) din[i] = N'($urandom);
    endtask

    // Monitor: accepted vectors are modelled as plain integer sums; results are
    // compared on every cycle out_valid is shown and popped on the output handshake.
    initial begin
        exp_t e;
        bit   prev_ov;
        prev_ov = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                sb.delete();
                prev_ov  = 1'b0;
                last_acc = -1;
            end else begin
                if (in_valid && in_ready) begin
                    e.sum = 0;
                    for (int i = 0; i < NUM_OPS; i++) e.sum += longint'(din[i]);
                    e.acc_cyc = cyc;
                    if (spacing_on && last_acc >= 0) chk("accept_spacing", 64'(cyc - last_acc), 64'(PER));
                    last_acc = cyc;
                    sb.push_back(e);
                end
                if (out_valid) begin
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_out_valid: got sum %0d with no pending transaction (cycle %0d)", sum, cyc);
                    end else begin
                        if (!prev_ov) chk("latency", 64'(cyc - sb[0].acc_cyc), 64'(LAT));
                        chk("sum", 64'(sum), 64'(sb[0].sum));
                        chk("in_ready_in_done", 64'(in_ready), 64'd0);
                        if (out_ready) void'(sb.pop_front());
                    end
                end
                prev_ov = out_valid;
            end
        end
    end

    // One transaction; exp < 0 means rely on the scoreboard only.
    task automatic send(input vec_t v, input int stall, input longint exp);
        int t;
        for (int i = 0; i < NUM_OPS; i++) din[i] = v[i];
        in_valid  = 1'b1;
        out_ready = (stall == 0);
        t = 0;
        while (!in_ready && t < 100) begin tick(); t++; end
        tick();
        in_valid = 1'b0;
        t = 0;
        while (!out_valid && t < 100) begin scramble(); tick(); t++; end
        if (!out_valid) begin
            checks++;
            errors++;
            $display("FAIL timeout: out_valid not seen within 100 cycles");
        end else if (exp >= 0) begin
            chk("sum_const", 64'(sum), 64'(exp));
        end
        repeat (stall) begin scramble(); in_valid = 1'b1; tick(); end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        chk("in_ready_after_hs", 64'(in_ready), 64'd1);
        chk("out_valid_after_hs", 64'(out_valid), 64'd0);
    endtask

    initial begin
        vec_t v;
        int   tbl [NUM_OPS] = '{13, 7, 64, 38, 21, 78, 93, 45};
        int   t;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        for (int i = 0; i < NUM_OPS; i++) din[i] = '0;
        repeat (3) tick();
        rst = 1'b0;
        chk("reset_in_ready", 64'(in_ready), 64'd1);
        chk("reset_out_valid", 64'(out_valid), 64'd0);
        chk("reset_sum", 64'(sum), 64'd0);

        for (int i = 0; i < NUM_OPS; i++) v[i] = '0;
        send(v, 0, 0);
        for (int i = 0; i < NUM_OPS; i++) v[i] = N'(1);
        send(v, 0, 8);
        for (int i = 0; i < NUM_OPS; i++) v[i] = N'(tbl[i]);
        send(v, 0, 359);
        for (int i = 0; i < NUM_OPS; i++) v[i] = N'(255);
        send(v, 0, 2040);
        for (int i = 0; i < NUM_OPS; i++) v[i] = N'(tbl[i]);
        send(v, 5, 359);

        // Reset during the 4th ACCUM cycle discards the transaction.
        for (int i = 0; i < NUM_OPS; i++) din[i] = N'(1);
        in_valid = 1'b1; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (3) begin scramble(); tick(); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midreset_in_ready", 64'(in_ready), 64'd1);
        chk("midreset_out_valid", 64'(out_valid), 64'd0);
        chk("midreset_sum", 64'(sum), 64'd0);
        repeat (2 * PER) tick();
        for (int i = 0; i < NUM_OPS; i++) v[i] = N'(1);
        send(v, 0, 8);

        for (int k = 0; k < 20; k++) begin
            for (int i = 0; i < NUM_OPS; i++) v[i] = N'($urandom);
            send(v, int'($urandom_range(0, 3)), -1);
        end

        // Back-to-back stream with in_valid held high.
        last_acc   = -1;
        spacing_on = 1'b1;
        out_ready  = 1'b1;
        in_valid   = 1'b1;
        repeat (6 * PER) begin scramble(); tick(); end
        in_valid = 1'b0;
        repeat (2 * PER) tick();
        spacing_on = 1'b0;

        t = 0;
        while (sb.size() != 0 && t < 100) begin tick(); t++; end
        chk("scoreboard_drained", 64'(sb.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
